// File: rtl/spell_mem_arb_pkg.sv
// rtl/spell_mem_arb_pkg.sv - shared encodings and constants for the spell_mem arbiter
package spell_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int WDOG_W = 8;

  localparam logic [7:0] ABORT_RDATA = 8'hFF;

endpackage

// File: rtl/spell_rr_arb2.sv
// rtl/spell_rr_arb2.sv - combinational two-way round-robin picker
module spell_rr_arb2
  import spell_mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  // A lone requester wins outright; on contention the port that did not win last time goes next
  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_A;
    if (req == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (req[PORT_B]) begin
      grant_idx = PORT_B;
    end
  end

endmodule

// File: rtl/spell_mem_arbiter.sv
// rtl/spell_mem_arbiter.sv - shares the spell_mem access port between core (A) and debug/loader (B)
module spell_mem_arbiter
  import spell_mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       a_req,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_data_in,
  input  logic       a_type_data,
  input  logic       a_write,
  output logic       a_ack,
  output logic       a_err,
  output logic [7:0] a_rdata,

  input  logic       b_req,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_data_in,
  input  logic       b_type_data,
  input  logic       b_write,
  output logic       b_ack,
  output logic       b_err,
  output logic [7:0] b_rdata,

  output logic       mem_select,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_type_data,
  output logic       mem_write,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_ready,

  output logic       busy,
  output logic       owner_b
);

  localparam logic [WDOG_W-1:0] TIMEOUT_L  = WDOG_W'(TIMEOUT_CYCLES);
  localparam logic              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  arb_state_e        state_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [7:0]        addr_q;
  logic [7:0]        wdata_q;
  logic              type_q;
  logic              write_q;
  logic [WDOG_W-1:0] wdog_q;
  logic              a_ack_q, b_ack_q;
  logic              a_err_q, b_err_q;
  logic [7:0]        a_rdata_q, b_rdata_q;

  logic              grant_valid;
  logic              grant_idx;

  spell_rr_arb2 u_rr (
    .req         ({b_req, a_req}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Single FSM: grant and latch in IDLE, hold the memory access in ISSUE, pulse the response in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_A;
      last_grant_q <= PORT_B;
      addr_q       <= '0;
      wdata_q      <= '0;
      type_q       <= 1'b0;
      write_q      <= 1'b0;
      wdog_q       <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= 8'h00;
      b_rdata_q    <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_idx;
            addr_q  <= (grant_idx == PORT_B) ? b_addr      : a_addr;
            wdata_q <= (grant_idx == PORT_B) ? b_data_in   : a_data_in;
            type_q  <= (grant_idx == PORT_B) ? b_type_data : a_type_data;
            write_q <= (grant_idx == PORT_B) ? b_write     : a_write;
            wdog_q  <= '0;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Ready is checked first so a completion on the final watchdog cycle is not reported as an abort
          if (mem_data_ready) begin
            if (owner_q == PORT_B) b_rdata_q <= mem_data_out;
            else                   a_rdata_q <= mem_data_out;
            a_ack_q      <= (owner_q == PORT_A);
            b_ack_q      <= (owner_q == PORT_B);
            a_err_q      <= 1'b0;
            b_err_q      <= 1'b0;
            last_grant_q <= owner_q;
            state_q      <= ST_RESP;
          end else if (TIMEOUT_EN && (wdog_q == TIMEOUT_L)) begin
            if (owner_q == PORT_B) b_rdata_q <= ABORT_RDATA;
            else                   a_rdata_q <= ABORT_RDATA;
            a_ack_q      <= (owner_q == PORT_A);
            b_ack_q      <= (owner_q == PORT_B);
            a_err_q      <= (owner_q == PORT_A);
            b_err_q      <= (owner_q == PORT_B);
            last_grant_q <= owner_q;
            state_q      <= ST_RESP;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
        end
        ST_RESP: begin
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          a_err_q <= 1'b0;
          b_err_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_ack         = a_ack_q;
  assign a_err         = a_err_q;
  assign a_rdata       = a_rdata_q;
  assign b_ack         = b_ack_q;
  assign b_err         = b_err_q;
  assign b_rdata       = b_rdata_q;
  assign mem_select    = (state_q == ST_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_data_in   = wdata_q;
  assign mem_type_data = type_q;
  assign mem_write     = write_q;
  assign busy          = (state_q != ST_IDLE);
  assign owner_b       = owner_q;

endmodule
